// File: rtl/dma_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dma_engine_pkg
//  Brief   : Shared state codes and types for the SRAM copy engine.
//  Rev     : 1.0  initial release
// ============================================================================
package dma_engine_pkg;

    typedef logic [1:0] dma_state_t;

    localparam dma_state_t DMA_STATE_IDLE    = 2'd0;
    localparam dma_state_t DMA_STATE_READ    = 2'd1;
    localparam dma_state_t DMA_STATE_CAPTURE = 2'd2;
    localparam dma_state_t DMA_STATE_WRITE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dma_engine_if.sv
`default_nettype none
// ============================================================================
//  Module  : dma_engine_if
//  Brief   : Control, processor-side and SRAM-side signals of the copy engine.
//  Rev     : 1.0  initial release
// ============================================================================
interface dma_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              dma_start;
    logic [ADDR_W-1:0] dma_src;
    logic [ADDR_W-1:0] dma_dst;
    logic [ADDR_W-1:0] dma_len;
    logic              dma_busy;
    logic              dma_done;
    logic [ADDR_W-1:0] dma_remaining;

    logic [ADDR_W-1:0] cpu_sram_ADDR;
    logic [DATA_W-1:0] cpu_sram_DI;
    logic              cpu_sram_EN;
    logic              cpu_sram_WE;

    logic [ADDR_W-1:0] sram_ADDR;
    logic [DATA_W-1:0] sram_DI;
    logic              sram_EN;
    logic              sram_WE;
    logic [DATA_W-1:0] sram_DO;

    modport master (
        output dma_start, dma_src, dma_dst, dma_len,
        output cpu_sram_ADDR, cpu_sram_DI, cpu_sram_EN, cpu_sram_WE,
        output sram_DO,
        input  dma_busy, dma_done, dma_remaining,
        input  sram_ADDR, sram_DI, sram_EN, sram_WE
    );

    modport slave (
        input  dma_start, dma_src, dma_dst, dma_len,
        input  cpu_sram_ADDR, cpu_sram_DI, cpu_sram_EN, cpu_sram_WE,
        input  sram_DO,
        output dma_busy, dma_done, dma_remaining,
        output sram_ADDR, sram_DI, sram_EN, sram_WE
    );
endinterface
`default_nettype wire

// File: rtl/dma_sram_mux.sv
`default_nettype none
// ============================================================================
//  Module  : dma_sram_mux
//  Brief   : Single-port SRAM request mux; the processor always wins.
//  Rev     : 1.0  initial release
// ============================================================================
module dma_sram_mux #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_di,
    input  logic              i_cpu_en,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_di,
    input  logic              i_dma_en,
    input  logic              i_dma_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_di,
    output logic              o_sram_en,
    output logic              o_sram_we
);

    always_comb begin
        o_sram_addr = '0;
        o_sram_di   = '0;
        o_sram_en   = 1'b0;
        o_sram_we   = 1'b0;
        if (i_cpu_en) begin
            o_sram_addr = i_cpu_addr;
            o_sram_di   = i_cpu_di;
            o_sram_en   = 1'b1;
            o_sram_we   = i_cpu_we;
        end else if (i_dma_en) begin
            o_sram_addr = i_dma_addr;
            o_sram_di   = i_dma_di;
            o_sram_en   = 1'b1;
            o_sram_we   = i_dma_we;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
//  Module  : dma_engine
//  Brief   : Word-by-word SRAM-to-SRAM copy engine sharing the port with a CPU.
//  Rev     : 1.0  initial release
// ============================================================================
module dma_engine
    import dma_engine_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    dma_engine_if.slave bus
);

    dma_state_t        r_state;
    dma_state_t        w_state_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_buf;
    logic              r_done;

    logic [ADDR_W-1:0] w_cnt_inc;
    logic              w_cpu_idle;
    logic              w_start_ok;
    logic              w_last;
    logic              w_busy;
    logic              w_dma_en;
    logic              w_dma_we;
    logic [ADDR_W-1:0] w_dma_addr;
    logic [DATA_W-1:0] w_dma_di;

    assign w_cnt_inc  = r_cnt + ADDR_W'(1);
    assign w_cpu_idle = ~bus.cpu_sram_EN;
    assign w_start_ok = bus.dma_start && (bus.dma_len != '0);
    assign w_last     = (w_cnt_inc == r_len);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= DMA_STATE_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DMA_STATE_IDLE:    if (w_start_ok) w_state_next = DMA_STATE_READ;
            DMA_STATE_READ:    if (w_cpu_idle) w_state_next = DMA_STATE_CAPTURE;
            DMA_STATE_CAPTURE: w_state_next = DMA_STATE_WRITE;
            DMA_STATE_WRITE:   if (w_cpu_idle) w_state_next = w_last ? DMA_STATE_IDLE : DMA_STATE_READ;
            default:           w_state_next = DMA_STATE_IDLE;
        endcase
    end

    // Start requests are only looked at in IDLE, so a busy engine ignores them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_buf  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DMA_STATE_IDLE: begin
                    if (w_start_ok) begin
                        r_src <= bus.dma_src;
                        r_dst <= bus.dma_dst;
                        r_len <= bus.dma_len;
                        r_cnt <= '0;
                    end else if (bus.dma_start) begin
                        r_done <= 1'b1;
                    end
                end
                DMA_STATE_CAPTURE: r_buf <= bus.sram_DO;
                DMA_STATE_WRITE: begin
                    if (w_cpu_idle) begin
                        r_cnt <= w_cnt_inc;
                        if (w_last) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by reset so an abandoned copy issues no last write.
    always_comb begin
        w_busy     = 1'b0;
        w_dma_en   = 1'b0;
        w_dma_we   = 1'b0;
        w_dma_addr = '0;
        w_dma_di   = '0;
        case (r_state)
            DMA_STATE_READ: begin
                w_busy     = 1'b1;
                w_dma_en   = reset;
                w_dma_addr = r_src + r_cnt;
            end
            DMA_STATE_CAPTURE: w_busy = 1'b1;
            DMA_STATE_WRITE: begin
                w_busy     = 1'b1;
                w_dma_en   = reset;
                w_dma_we   = reset;
                w_dma_addr = r_dst + r_cnt;
                w_dma_di   = r_buf;
            end
            default: ;
        endcase
    end

    assign bus.dma_busy      = w_busy;
    assign bus.dma_done      = r_done;
    assign bus.dma_remaining = w_busy ? (r_len - r_cnt) : '0;

    dma_sram_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram_mux (
        .i_cpu_addr  (bus.cpu_sram_ADDR),
        .i_cpu_di    (bus.cpu_sram_DI),
        .i_cpu_en    (bus.cpu_sram_EN),
        .i_cpu_we    (bus.cpu_sram_WE),
        .i_dma_addr  (w_dma_addr),
        .i_dma_di    (w_dma_di),
        .i_dma_en    (w_dma_en),
        .i_dma_we    (w_dma_we),
        .o_sram_addr (bus.sram_ADDR),
        .o_sram_di   (bus.sram_DI),
        .o_sram_en   (bus.sram_EN),
        .o_sram_we   (bus.sram_WE)
    );

endmodule
`default_nettype wire
